pe_tile_streamer: RTL and testbench

// CU-side initiator for the PE array interface. Accepts a tile command (reduction length K),

---
 rtl/nmcu_pkg.sv | 13 +
 rtl/pe_result_buffer.sv | 36 +++
 rtl/pe_tile_streamer.sv | 184 ++++++++++++++++++
 tb/tb_pe_tile_streamer.sv | 327 ++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/nmcu_pkg.sv
// Shared types and constants for the NMCU compute-unit slice.
package nmcu_pkg;

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_STREAM = 2'd1,
    ST_DRAIN  = 2'd2,
    ST_UNLOAD = 2'd3
  } pe_stream_state_e;

  localparam int PE_STREAM_K_WIDTH = 16;

endpackage

// File: rtl/pe_result_buffer.sv
// Psum tile capture registers with a row-select mux for the unload phase.
module pe_result_buffer
  import nmcu_pkg::*;
#(
  parameter int PSUM_WIDTH = 32,
  parameter int PE_ROWS    = 4,
  parameter int PE_COLS    = 4
) (
  input  logic                                  clk,
  input  logic                                  rst_n,
  input  logic                                  capture_en,
  input  logic [PSUM_WIDTH*PE_ROWS*PE_COLS-1:0] pe_result,
  input  logic [$clog2(PE_ROWS)-1:0]            idx,
  output logic [PSUM_WIDTH*PE_COLS-1:0]         row
);

  localparam int ROW_W = PSUM_WIDTH * PE_COLS;

  logic [ROW_W-1:0] rows_r [PE_ROWS];

  // Capture the whole tile in one cycle; rows stay frozen until the next capture.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int r = 0; r < PE_ROWS; r++) begin
        rows_r[r] <= '0;
      end
    end else if (capture_en) begin
      for (int r = 0; r < PE_ROWS; r++) begin
        rows_r[r] <= pe_result[r*ROW_W +: ROW_W];
      end
    end
  end

  assign row = rows_r[idx];

endmodule

// File: rtl/pe_tile_streamer.sv
// CU-side tile initiator: streams K operand beats into the PE array, waits for K done
// pulses, then unloads the captured psum tile row by row. Optional watchdog: PE_STREAMER_TIMEOUT_EN.
module pe_tile_streamer
  import nmcu_pkg::*;
#(
  parameter int DATA_WIDTH     = 8,
  parameter int PSUM_WIDTH     = 32,
  parameter int PE_ROWS        = 4,
  parameter int PE_COLS        = 4,
  parameter int K_WIDTH        = PE_STREAM_K_WIDTH,
  parameter int TIMEOUT_CYCLES = 64
) (
  input  logic                                  clk,
  input  logic                                  rst_n,
  input  logic                                  cmd_valid_i,
  output logic                                  cmd_ready_o,
  input  logic [K_WIDTH-1:0]                    cmd_k_i,
  input  logic                                  cmd_accum_i,
  input  logic                                  opnd_valid_i,
  output logic                                  opnd_ready_o,
  input  logic [DATA_WIDTH*PE_ROWS-1:0]         opnd_a_i,
  input  logic [DATA_WIDTH*PE_COLS-1:0]         opnd_b_i,
  output logic                                  pe_cmd_valid_o,
  input  logic                                  pe_cmd_ready_i,
  output logic [PE_ROWS-1:0]                    pe_accum_en_o,
  output logic [DATA_WIDTH*PE_ROWS-1:0]         pe_operand_a_o,
  output logic [DATA_WIDTH*PE_COLS-1:0]         pe_operand_b_o,
  input  logic                                  pe_done_i,
  input  logic [PSUM_WIDTH*PE_ROWS*PE_COLS-1:0] pe_result_i,
  output logic                                  res_valid_o,
  input  logic                                  res_ready_i,
  output logic [PSUM_WIDTH*PE_COLS-1:0]         res_row_o,
  output logic [$clog2(PE_ROWS)-1:0]            res_idx_o,
  output logic                                  res_last_o,
  output logic                                  busy_o,
  output logic                                  timeout_err_o
);

  localparam int IDX_W = $clog2(PE_ROWS);

  pe_stream_state_e   state_r;
  logic [K_WIDTH-1:0] k_r;
  logic               accum_r;
  logic [K_WIDTH-1:0] beat_cnt_r;
  logic [K_WIDTH-1:0] done_cnt_r;
  logic [IDX_W-1:0]   idx_r;

  logic cmd_fire_s;
  logic beat_fire_s;
  logic last_beat_s;
  logic done_beat_s;
  logic capture_s;
  logic res_fire_s;

  assign cmd_ready_o    = (state_r == ST_IDLE);
  assign busy_o         = (state_r != ST_IDLE);
  assign opnd_ready_o   = (state_r == ST_STREAM) & pe_cmd_ready_i;
  assign pe_cmd_valid_o = (state_r == ST_STREAM) & opnd_valid_i;
  assign pe_operand_a_o = opnd_a_i;
  assign pe_operand_b_o = opnd_b_i;
  assign res_valid_o    = (state_r == ST_UNLOAD);
  assign res_idx_o      = idx_r;
  assign res_last_o     = res_valid_o & (idx_r == IDX_W'(PE_ROWS - 1));

  assign cmd_fire_s  = cmd_valid_i & cmd_ready_o;
  assign beat_fire_s = pe_cmd_valid_o & pe_cmd_ready_i;
  assign last_beat_s = ((beat_cnt_r + K_WIDTH'(1)) == k_r);
  assign done_beat_s = pe_done_i & ((state_r == ST_STREAM) | (state_r == ST_DRAIN));
  assign capture_s   = done_beat_s & ((done_cnt_r + K_WIDTH'(1)) == k_r);
  assign res_fire_s  = res_valid_o & res_ready_i;

  // First beat of a tile honours the command's accumulate flag; later beats always accumulate.
  always_comb begin
    pe_accum_en_o = {PE_ROWS{1'b0}};
    if (state_r == ST_STREAM) begin
      if (beat_cnt_r == K_WIDTH'(0)) begin
        pe_accum_en_o = {PE_ROWS{accum_r}};
      end else begin
        pe_accum_en_o = {PE_ROWS{1'b1}};
      end
    end else begin
      pe_accum_en_o = {PE_ROWS{1'b0}};
    end
  end

`ifdef PE_STREAMER_TIMEOUT_EN
  localparam int WD_W = $clog2(TIMEOUT_CYCLES + 1);
  logic [WD_W-1:0] wd_cnt_r;
  logic            timeout_err_r;
  assign timeout_err_o = timeout_err_r;
`else
  assign timeout_err_o = 1'b0;
`endif

  // Tile sequencer: command latch, beat/done counting, unload row index.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_r    <= ST_IDLE;
      k_r        <= '0;
      accum_r    <= 1'b0;
      beat_cnt_r <= '0;
      done_cnt_r <= '0;
      idx_r      <= '0;
`ifdef PE_STREAMER_TIMEOUT_EN
      wd_cnt_r      <= '0;
      timeout_err_r <= 1'b0;
`endif
    end else begin
      case (state_r)
        ST_IDLE: begin
          if (cmd_fire_s) begin
            k_r        <= cmd_k_i;
            accum_r    <= cmd_accum_i;
            beat_cnt_r <= '0;
            done_cnt_r <= '0;
            idx_r      <= '0;
`ifdef PE_STREAMER_TIMEOUT_EN
            wd_cnt_r      <= '0;
            timeout_err_r <= 1'b0;
`endif
            if (cmd_k_i != K_WIDTH'(0)) begin
              state_r <= ST_STREAM;
            end
          end
        end
        ST_STREAM: begin
          if (beat_fire_s) begin
            beat_cnt_r <= beat_cnt_r + K_WIDTH'(1);
          end
          if (done_beat_s) begin
            done_cnt_r <= done_cnt_r + K_WIDTH'(1);
          end
          if (capture_s) begin
            state_r <= ST_UNLOAD;
          end else if (beat_fire_s && last_beat_s) begin
            state_r <= ST_DRAIN;
          end
        end
        ST_DRAIN: begin
          if (done_beat_s) begin
            done_cnt_r <= done_cnt_r + K_WIDTH'(1);
          end
          if (capture_s) begin
            state_r <= ST_UNLOAD;
          end
`ifdef PE_STREAMER_TIMEOUT_EN
          else if (wd_cnt_r == WD_W'(TIMEOUT_CYCLES - 1)) begin
            timeout_err_r <= 1'b1;
            state_r       <= ST_IDLE;
          end else begin
            wd_cnt_r <= wd_cnt_r + WD_W'(1);
          end
`endif
        end
        ST_UNLOAD: begin
          if (res_fire_s) begin
            idx_r <= idx_r + IDX_W'(1);
            if (res_last_o) begin
              idx_r   <= '0;
              state_r <= ST_IDLE;
            end
          end
        end
        default: begin
          state_r <= ST_IDLE;
        end
      endcase
    end
  end

  pe_result_buffer #(
    .PSUM_WIDTH (PSUM_WIDTH),
    .PE_ROWS    (PE_ROWS),
    .PE_COLS    (PE_COLS)
  ) u_result_buffer (
    .clk        (clk),
    .rst_n      (rst_n),
    .capture_en (capture_s),
    .pe_result  (pe_result_i),
    .idx        (idx_r),
    .row        (res_row_o)
  );

endmodule

// File: tb/tb_pe_tile_streamer.sv
// Scoreboard bench for pe_tile_streamer with a 10-cycle PE array environment model.
module tb_pe_tile_streamer;

  logic         clk = 1'b0;
  logic         rst_n;
  logic         cmd_valid_i;
  logic         cmd_ready_o;
  logic [15:0]  cmd_k_i;
  logic         cmd_accum_i;
  logic         opnd_valid_i;
  logic         opnd_ready_o;
  logic [31:0]  opnd_a_i;
  logic [31:0]  opnd_b_i;
  logic         pe_cmd_valid_o;
  logic         pe_cmd_ready_i;
  logic [3:0]   pe_accum_en_o;
  logic [31:0]  pe_operand_a_o;
  logic [31:0]  pe_operand_b_o;
  logic         pe_done_i;
  logic [511:0] pe_result_i;
  logic         res_valid_o;
  logic         res_ready_i;
  logic [127:0] res_row_o;
  logic [1:0]   res_idx_o;
  logic         res_last_o;
  logic         busy_o;
  logic         timeout_err_o;

  always #5 clk = ~clk;

  pe_tile_streamer #(
    .DATA_WIDTH(8), .PSUM_WIDTH(32), .PE_ROWS(4), .PE_COLS(4), .K_WIDTH(16), .TIMEOUT_CYCLES(64)
  ) dut (
    .clk(clk), .rst_n(rst_n),
    .cmd_valid_i(cmd_valid_i), .cmd_ready_o(cmd_ready_o), .cmd_k_i(cmd_k_i), .cmd_accum_i(cmd_accum_i),
    .opnd_valid_i(opnd_valid_i), .opnd_ready_o(opnd_ready_o), .opnd_a_i(opnd_a_i), .opnd_b_i(opnd_b_i),
    .pe_cmd_valid_o(pe_cmd_valid_o), .pe_cmd_ready_i(pe_cmd_ready_i), .pe_accum_en_o(pe_accum_en_o),
    .pe_operand_a_o(pe_operand_a_o), .pe_operand_b_o(pe_operand_b_o),
    .pe_done_i(pe_done_i), .pe_result_i(pe_result_i),
    .res_valid_o(res_valid_o), .res_ready_i(res_ready_i), .res_row_o(res_row_o),
    .res_idx_o(res_idx_o), .res_last_o(res_last_o), .busy_o(busy_o), .timeout_err_o(timeout_err_o)
  );

  typedef struct { logic [31:0] a; logic [31:0] b; logic [3:0] en; } beat_t;
  typedef struct { logic [127:0] row; logic [1:0] idx; logic last; } row_t;

  beat_t       exp_beat_q[$];
  row_t        exp_row_q[$];
  logic [31:0] ref_psum [4][4];
  logic [31:0] arr_psum [4][4];
  logic [9:0]  done_pipe;
  bit          suppress_done = 1'b0;
  bit          bp_low = 1'b0;
  bit          rdy_force = 1'b0;
  int          checks = 0;
  int          failures = 0;

  task automatic chk(input string name, input logic [127:0] act, input logic [127:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%0h expected=%0h", name, act, exp);
    end
  endtask

  // PE array environment: accumulates products per accepted beat, done pulse 10 cycles later.
  initial begin
    done_pipe = '0;
    for (int r = 0; r < 4; r++) for (int c = 0; c < 4; c++) arr_psum[r][c] = 32'd0;
    forever begin
      @(negedge clk);
      if (!rst_n) begin
        done_pipe = '0;
        pe_done_i = 1'b0;
      end else begin
        logic fire;
        fire = pe_cmd_valid_o & pe_cmd_ready_i;
        if (fire) begin
          if (exp_beat_q.size() == 0) begin
            chk("extra_beat", 1'b1, 1'b0);
          end else begin
            beat_t b;
            b = exp_beat_q.pop_front();
            chk("operand_a", pe_operand_a_o, b.a);
            chk("operand_b", pe_operand_b_o, b.b);
            chk("accum_en", pe_accum_en_o, b.en);
          end
          for (int r = 0; r < 4; r++)
            for (int c = 0; c < 4; c++)
              arr_psum[r][c] = (pe_accum_en_o[r] ? arr_psum[r][c] : 32'd0) +
                               32'(pe_operand_a_o[r*8 +: 8]) * 32'(pe_operand_b_o[c*8 +: 8]);
        end
        pe_done_i = done_pipe[9] & ~suppress_done;
        done_pipe = {done_pipe[8:0], fire};
        for (int r = 0; r < 4; r++)
          for (int c = 0; c < 4; c++)
            pe_result_i[(r*4+c)*32 +: 32] = arr_psum[r][c];
      end
    end
  end

  // Result monitor: pops the scoreboard on each accepted row, checks hold under backpressure.
  initial begin
    logic         hold;
    logic [127:0] held_row;
    logic [1:0]   held_idx;
    hold = 1'b0;
    held_row = '0;
    held_idx = '0;
    forever begin
      @(negedge clk);
      if (!rst_n || !res_valid_o) begin
        hold = 1'b0;
      end else begin
        chk("cmd_ready_in_unload", cmd_ready_o, 1'b0);
        if (hold) begin
          chk("row_stable", res_row_o, held_row);
          chk("idx_stable", res_idx_o, held_idx);
        end
        if (res_ready_i) begin
          hold = 1'b0;
          if (exp_row_q.size() == 0) begin
            chk("extra_row", 1'b1, 1'b0);
          end else begin
            row_t e;
            e = exp_row_q.pop_front();
            chk("res_row", res_row_o, e.row);
            chk("res_idx", res_idx_o, e.idx);
            chk("res_last", res_last_o, e.last);
          end
        end else begin
          hold = 1'b1;
          held_row = res_row_o;
          held_idx = res_idx_o;
        end
      end
    end
  end

  // Random handshake partners on the PE side and the result sink.
  initial begin
    pe_cmd_ready_i = 1'b0;
    res_ready_i = 1'b0;
    forever begin
      @(posedge clk);
      #1;
      pe_cmd_ready_i = rdy_force ? 1'b1 : ($urandom_range(0, 3) != 0);
      res_ready_i = bp_low ? 1'b0 : ($urandom_range(0, 2) != 0);
    end
  end

  // mode 0: random bubbles, 1: always valid, 2: valid pattern 1,0,1,1,0,1.
  task automatic run_tile(input int k, input bit acc, input bit fixed_ab, input int mode,
                          input bit expect_rows, input int abort_steps);
    logic [31:0] ba[$];
    logic [31:0] bb[$];
    logic [31:0] sum [4][4];
    bit          pat[6] = '{1'b1, 1'b0, 1'b1, 1'b1, 1'b0, 1'b1};
    int          i;
    int          step;
    logic        fired;
    for (int r = 0; r < 4; r++) for (int c = 0; c < 4; c++) sum[r][c] = 32'd0;
    for (int n = 0; n < k; n++) begin
      beat_t bt;
      bt.a = fixed_ab ? {4{8'd1}} : $urandom;
      bt.b = fixed_ab ? {4{8'd2}} : $urandom;
      bt.en = (n == 0) ? {4{acc}} : 4'hF;
      ba.push_back(bt.a);
      bb.push_back(bt.b);
      exp_beat_q.push_back(bt);
      for (int r = 0; r < 4; r++)
        for (int c = 0; c < 4; c++)
          sum[r][c] += 32'(bt.a[r*8 +: 8]) * 32'(bt.b[c*8 +: 8]);
    end
    if (k > 0) begin
      for (int r = 0; r < 4; r++)
        for (int c = 0; c < 4; c++)
          ref_psum[r][c] = acc ? ref_psum[r][c] + sum[r][c] : sum[r][c];
    end
    if (expect_rows && k > 0) begin
      for (int r = 0; r < 4; r++) begin
        row_t e;
        for (int c = 0; c < 4; c++) e.row[c*32 +: 32] = ref_psum[r][c];
        e.idx = 2'(r);
        e.last = (r == 3);
        exp_row_q.push_back(e);
      end
    end
    @(posedge clk);
    #1;
    cmd_valid_i = 1'b1;
    cmd_k_i = 16'(k);
    cmd_accum_i = acc;
    for (int n = 0; n < 500; n++) begin
      @(negedge clk);
      if (cmd_ready_o) break;
    end
    chk("cmd_accept", cmd_ready_o, 1'b1);
    @(posedge clk);
    #1;
    cmd_valid_i = 1'b0;
    i = 0;
    step = 0;
    while (i < k && step < 2000 && step < abort_steps) begin
      opnd_valid_i = (mode == 1) ? 1'b1 : (mode == 2) ? pat[step % 6] : ($urandom_range(0, 3) != 0);
      opnd_a_i = ba[i];
      opnd_b_i = bb[i];
      @(negedge clk);
      fired = opnd_valid_i & opnd_ready_o;
      @(posedge clk);
      #1;
      if (fired) i++;
      step++;
    end
    opnd_valid_i = 1'b0;
    if (abort_steps >= 2000) begin
      chk("beats_sent", i, k);
      for (int n = 0; n < 3000; n++) begin
        @(negedge clk);
        if (!busy_o) break;
      end
      chk("tile_done", busy_o, 1'b0);
      chk("beats_consumed", exp_beat_q.size(), 0);
      chk("rows_consumed", exp_row_q.size(), 0);
    end
  endtask

  initial begin
    rst_n = 1'b0;
    cmd_valid_i = 1'b0;
    cmd_k_i = '0;
    cmd_accum_i = 1'b0;
    opnd_valid_i = 1'b0;
    opnd_a_i = '0;
    opnd_b_i = '0;
    pe_done_i = 1'b0;
    pe_result_i = '0;
    for (int r = 0; r < 4; r++) for (int c = 0; c < 4; c++) ref_psum[r][c] = 32'd0;
    repeat (3) @(posedge clk);
    @(negedge clk);
    chk("rst_cmd_ready", cmd_ready_o, 1'b1);
    chk("rst_busy", busy_o, 1'b0);
    chk("rst_res_valid", res_valid_o, 1'b0);
    chk("rst_timeout", timeout_err_o, 1'b0);
    chk("rst_row", res_row_o, 128'd0);
    chk("rst_idx", res_idx_o, 2'd0);
    @(posedge clk);
    #1;
    rst_n = 1'b1;

    rdy_force = 1'b1;
    run_tile(3, 1'b0, 1'b1, 1, 1'b1, 2000);
    run_tile(4, 1'b0, 1'b0, 2, 1'b1, 2000);
    run_tile(2, 1'b1, 1'b0, 1, 1'b1, 2000);
    rdy_force = 1'b0;

    fork
      run_tile(3, 1'b1, 1'b0, 0, 1'b1, 2000);
      begin
        for (int n = 0; n < 2000; n++) begin
          @(negedge clk);
          if (res_valid_o) break;
        end
        chk("unload_reached", res_valid_o, 1'b1);
        @(posedge clk);
        #1;
        bp_low = 1'b1;
        repeat (5) @(posedge clk);
        #1;
        bp_low = 1'b0;
      end
    join

    run_tile(0, 1'b0, 1'b0, 1, 1'b0, 2000);
    opnd_valid_i = 1'b1;
    for (int n = 0; n < 6; n++) begin
      @(negedge clk);
      chk("k0_busy", busy_o, 1'b0);
      chk("k0_pe_cmd_valid", pe_cmd_valid_o, 1'b0);
    end
    opnd_valid_i = 1'b0;

    for (int t = 0; t < 20; t++) begin
      run_tile($urandom_range(1, 8), 1'($urandom_range(0, 1)), 1'b0, 0, 1'b1, 2000);
    end
    chk("no_timeout_err", timeout_err_o, 1'b0);

`ifdef PE_STREAMER_TIMEOUT_EN
    suppress_done = 1'b1;
    run_tile(2, 1'b0, 1'b0, 1, 1'b0, 2000);
    chk("timeout_err_set", timeout_err_o, 1'b1);
    chk("timeout_idle", cmd_ready_o, 1'b1);
    suppress_done = 1'b0;
    run_tile(1, 1'b0, 1'b0, 1, 1'b1, 2000);
    chk("timeout_err_cleared", timeout_err_o, 1'b0);
`endif

    rdy_force = 1'b1;
    run_tile(6, 1'b0, 1'b0, 1, 1'b1, 3);
    opnd_valid_i = 1'b1;
    rst_n = 1'b0;
    @(negedge clk);
    chk("mid_rst_cmd_ready", cmd_ready_o, 1'b1);
    chk("mid_rst_busy", busy_o, 1'b0);
    chk("mid_rst_pe_cmd_valid", pe_cmd_valid_o, 1'b0);
    chk("mid_rst_opnd_ready", opnd_ready_o, 1'b0);
    chk("mid_rst_res_valid", res_valid_o, 1'b0);
    chk("mid_rst_timeout", timeout_err_o, 1'b0);
    chk("mid_rst_idx", res_idx_o, 2'd0);
    exp_beat_q.delete();
    exp_row_q.delete();
    @(posedge clk);
    #1;
    opnd_valid_i = 1'b0;
    rst_n = 1'b1;
    rdy_force = 1'b0;
    repeat (15) @(posedge clk);
    run_tile(3, 1'b0, 1'b0, 0, 1'b1, 2000);

    repeat (20) @(posedge clk);
    chk("final_beats_empty", exp_beat_q.size(), 0);
    chk("final_rows_empty", exp_row_q.size(), 0);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
